// File: rtl/writeback_arbiter.sv
// Register-file writeback arbiter: merges the pipeline writeback with buffered mul/div results.
// Optional same-cycle MDU bypass when the buffer is empty: define WB_BYPASS_EN.
module writeback_arbiter #(
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_pipe_valid,
    input  logic        i_pipe_write_rd,
    input  logic [4:0]  i_pipe_rd,
    input  logic [31:0] i_pipe_value,
    input  logic        i_mdu_valid,
    input  logic [4:0]  i_mdu_rd,
    input  logic [31:0] i_mdu_value,
    output logic        o_mdu_ready,
    output logic        o_pipe_grant,
    output logic        o_stall_req,
    output logic        o_wb_valid,
    output logic [4:0]  o_wb_rd,
    output logic [31:0] o_wb_value,
    output logic [31:0] o_pending_mask
);

    localparam int CW = 4;

    logic [4:0]    r_fifo_rd  [2];
    logic [31:0]   r_fifo_val [2];
    logic          r_head;
    logic [1:0]    r_count;
    logic [CW-1:0] r_starve;
    logic          r_stall;
    logic [31:0]   r_mask;

    logic          w_empty;
    logic          w_pipe_req;
    logic          w_mdu_acc;
    logic          w_mdu_keep;
    logic          w_bypass;
    logic          w_pop;
    logic          w_push;
    logic          w_tail;
    logic          w_head_n;
    logic [1:0]    w_count_n;
    logic [4:0]    w_rd_n [2];
    logic [31:0]   w_mask_n;
    logic [CW-1:0] w_starve_n;
    logic          w_stall_n;

    assign w_empty      = (r_count == 2'd0);
    assign o_mdu_ready  = ~i_reset & (r_count < 2'd2);
    assign w_mdu_acc    = i_mdu_valid & o_mdu_ready;
    assign w_mdu_keep   = w_mdu_acc & (i_mdu_rd != 5'd0);
    assign w_pipe_req   = i_pipe_valid & i_pipe_write_rd & (i_pipe_rd != 5'd0);
    assign o_pipe_grant = ~i_reset & w_pipe_req & ~r_stall;
    assign w_pop        = ~i_reset & ~w_empty & (r_stall | ~w_pipe_req);
    assign o_stall_req  = r_stall;
    assign o_pending_mask = r_mask;

`ifdef WB_BYPASS_EN
    assign w_bypass = w_empty & ~r_stall & ~w_pipe_req & w_mdu_keep;
`else
    assign w_bypass = 1'b0;
`endif

    assign w_push = w_mdu_keep & ~w_bypass;
    // Push only happens below count 2, so the tail slot is head + count modulo 2.
    assign w_tail = r_head ^ r_count[0];

    always_comb begin
        o_wb_valid = 1'b0;
        o_wb_rd    = 5'd0;
        o_wb_value = 32'd0;
        if (w_pop) begin
            o_wb_valid = 1'b1;
            o_wb_rd    = r_fifo_rd[r_head];
            o_wb_value = r_fifo_val[r_head];
        end else if (o_pipe_grant) begin
            o_wb_valid = 1'b1;
            o_wb_rd    = i_pipe_rd;
            o_wb_value = i_pipe_value;
        end else if (w_bypass) begin
            o_wb_valid = 1'b1;
            o_wb_rd    = i_mdu_rd;
            o_wb_value = i_mdu_value;
        end
    end

    // Mask is built from the post-edge contents so a popped rd drops out on the same edge.
    always_comb begin
        w_head_n  = r_head ^ w_pop;
        w_count_n = r_count + {1'b0, w_push} - {1'b0, w_pop};
        w_mask_n  = 32'd0;
        for (int i = 0; i < 2; i++) begin
            w_rd_n[i] = (w_push && (w_tail == 1'(i))) ? i_mdu_rd : r_fifo_rd[i];
            if ({1'b0, 1'(i) ^ w_head_n} < w_count_n)
                w_mask_n[w_rd_n[i]] = 1'b1;
        end
    end

    always_comb begin
        if (w_empty || w_pop)
            w_starve_n = '0;
        else if (r_starve < CW'(STARVE_LIMIT))
            w_starve_n = r_starve + 4'd1;
        else
            w_starve_n = r_starve;
        w_stall_n = ~w_pop & (r_stall | (w_starve_n == CW'(STARVE_LIMIT)));
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_head   <= 1'b0;
            r_count  <= 2'd0;
            r_starve <= '0;
            r_stall  <= 1'b0;
            r_mask   <= 32'd0;
        end else begin
            r_head   <= w_head_n;
            r_count  <= w_count_n;
            r_starve <= w_starve_n;
            r_stall  <= w_stall_n;
            r_mask   <= w_mask_n;
        end
    end

    always_ff @(posedge i_clk) begin
        if (w_push) begin
            r_fifo_rd[w_tail]  <= i_mdu_rd;
            r_fifo_val[w_tail] <= i_mdu_value;
        end
    end

endmodule

// File: tb/tb_writeback_arbiter.sv
// Directed bench for writeback_arbiter; expected port writes go through a scoreboard queue.
module tb_writeback_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        pipe_valid, pipe_write_rd;
    logic [4:0]  pipe_rd;
    logic [31:0] pipe_value;
    logic        mdu_valid;
    logic [4:0]  mdu_rd;
    logic [31:0] mdu_value;
    logic        mdu_ready, pipe_grant, stall_req, wb_valid;
    logic [4:0]  wb_rd;
    logic [31:0] wb_value, pending_mask;

    int n_tests = 0;
    int n_fail  = 0;
    logic [36:0] exp_q[$];

    always #5 clk = ~clk;

    writeback_arbiter #(.STARVE_LIMIT(4)) dut (
        .i_clk(clk), .i_reset(reset),
        .i_pipe_valid(pipe_valid), .i_pipe_write_rd(pipe_write_rd),
        .i_pipe_rd(pipe_rd), .i_pipe_value(pipe_value),
        .i_mdu_valid(mdu_valid), .i_mdu_rd(mdu_rd), .i_mdu_value(mdu_value),
        .o_mdu_ready(mdu_ready), .o_pipe_grant(pipe_grant), .o_stall_req(stall_req),
        .o_wb_valid(wb_valid), .o_wb_rd(wb_rd), .o_wb_value(wb_value),
        .o_pending_mask(pending_mask)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic pv, input logic pw, input logic [4:0] prd, input logic [31:0] pval,
                         input logic mv, input logic [4:0] mrd, input logic [31:0] mval);
        pipe_valid    = pv;
        pipe_write_rd = pw;
        pipe_rd       = prd;
        pipe_value    = pval;
        mdu_valid     = mv;
        mdu_rd        = mrd;
        mdu_value     = mval;
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    endtask

    task automatic expect_wb(input logic [4:0] rd, input logic [31:0] val);
        exp_q.push_back({rd, val});
    endtask

    task automatic to_sample();
        @(negedge clk);
    endtask

    task automatic to_next();
        @(posedge clk);
        #1;
    endtask

    // Monitor: every negedge either a write matches the queue head or the port is fully quiet.
    always @(negedge clk) begin
        logic [36:0] e;
        n_tests++;
        if (wb_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL wb_unexpected: got rd=%0d val=0x%0h, expected no write at %0t",
                         wb_rd, wb_value, $time);
            end else begin
                e = exp_q.pop_front();
                if ({wb_rd, wb_value} !== e) begin
                    n_fail++;
                    $display("FAIL wb_data: got rd=%0d val=0x%0h, expected rd=%0d val=0x%0h at %0t",
                             wb_rd, wb_value, e[36:32], e[31:0], $time);
                end
            end
        end else if (wb_valid !== 1'b0 || wb_rd !== 5'd0 || wb_value !== 32'd0) begin
            n_fail++;
            $display("FAIL wb_idle: got valid=%b rd=%0d val=0x%0h, expected 0/0/0 at %0t",
                     wb_valid, wb_rd, wb_value, $time);
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset with live requests on both inputs: nothing may be accepted or granted.
        reset = 1'b1;
        drive(1'b1, 1'b1, 5'd3, 32'h33, 1'b1, 5'd4, 32'h44);
        to_next();
        to_sample();
        check("rst_mdu_ready", 32'(mdu_ready), 32'd0);
        check("rst_pipe_grant", 32'(pipe_grant), 32'd0);
        check("rst_wb_valid", 32'(wb_valid), 32'd0);
        to_next();
        reset = 1'b0;
        idle();

        // Idle after reset
        for (int k = 0; k < 5; k++) begin
            to_sample();
            check("idle_ready", 32'(mdu_ready), 32'd1);
            check("idle_wb_valid", 32'(wb_valid), 32'd0);
            check("idle_mask", pending_mask, 32'd0);
            check("idle_stall", 32'(stall_req), 32'd0);
            to_next();
        end

        // Single MDU result into an empty arbiter
        drive(1'b0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd5, 32'h1234);
`ifdef WB_BYPASS_EN
        expect_wb(5'd5, 32'h1234);
`endif
        to_sample();
        check("b_ready", 32'(mdu_ready), 32'd1);
        to_next();
        idle();
`ifdef WB_BYPASS_EN
        to_sample();
        check("b_mask_bypass", pending_mask, 32'd0);
        to_next();
`else
        expect_wb(5'd5, 32'h1234);
        to_sample();
        check("b_mask_pending", pending_mask, 32'h0000_0020);
        to_next();
        to_sample();
        check("b_mask_cleared", pending_mask, 32'd0);
        to_next();
`endif

        // Pipeline hogs the port; MDU results queue up until starvation forces a stall.
        for (int k = 0; k <= 6; k++) begin
            logic        mv;
            logic [4:0]  mrd;
            logic [31:0] mval;
            mv   = 1'b1;
            mrd  = (k == 0) ? 5'd7 : (k == 1) ? 5'd8 : 5'd9;
            mval = (k == 0) ? 32'h7007 : (k == 1) ? 32'h8008 : 32'h9009;
            drive(1'b1, 1'b1, 5'd3, 32'h300 + 32'(k), mv, mrd, mval);
            if (k == 5) expect_wb(5'd7, 32'h7007);
            else        expect_wb(5'd3, 32'h300 + 32'(k));
            to_sample();
            case (k)
                0: check("c_ready0", 32'(mdu_ready), 32'd1);
                1: check("c_mask1", pending_mask, 32'h0000_0080);
                2: begin
                    check("c_ready2", 32'(mdu_ready), 32'd0);
                    check("c_mask2", pending_mask, 32'h0000_0180);
                    check("c_stall2", 32'(stall_req), 32'd0);
                end
                3: check("c_stall3", 32'(stall_req), 32'd0);
                4: begin
                    check("c_stall4", 32'(stall_req), 32'd0);
                    check("c_grant4", 32'(pipe_grant), 32'd1);
                end
                5: begin
                    check("c_stall5", 32'(stall_req), 32'd1);
                    check("c_grant5", 32'(pipe_grant), 32'd0);
                    check("c_ready5", 32'(mdu_ready), 32'd0);
                end
                default: begin
                    check("c_stall6", 32'(stall_req), 32'd0);
                    check("c_ready6", 32'(mdu_ready), 32'd1);
                    check("c_mask6", pending_mask, 32'h0000_0100);
                end
            endcase
            to_next();
        end
        idle();
        expect_wb(5'd8, 32'h8008);
        to_sample();
        check("c_mask7", pending_mask, 32'h0000_0300);
        to_next();
        expect_wb(5'd9, 32'h9009);
        to_sample();
        check("c_mask8", pending_mask, 32'h0000_0200);
        to_next();
        to_sample();
        check("c_mask9", pending_mask, 32'd0);
        to_next();

        // Push and pop together at count 1
        drive(1'b1, 1'b1, 5'd3, 32'h3100, 1'b1, 5'd10, 32'hA0A0);
        expect_wb(5'd3, 32'h3100);
        to_next();
        drive(1'b0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd11, 32'hB0B0);
        expect_wb(5'd10, 32'hA0A0);
        to_sample();
        check("d_ready", 32'(mdu_ready), 32'd1);
        check("d_stall", 32'(stall_req), 32'd0);
        to_next();
        idle();
        expect_wb(5'd11, 32'hB0B0);
        to_sample();
        check("d_mask_one", pending_mask, 32'h0000_0800);
        to_next();
        to_sample();
        check("d_mask_empty", pending_mask, 32'd0);
        to_next();

        // x0 pipeline write lets the buffered head through; x0 MDU result is dropped.
        drive(1'b1, 1'b1, 5'd3, 32'h3200, 1'b1, 5'd12, 32'hC0C0);
        expect_wb(5'd3, 32'h3200);
        to_next();
        drive(1'b1, 1'b1, 5'd0, 32'hDEAD, 1'b0, 5'd0, 32'd0);
        expect_wb(5'd12, 32'hC0C0);
        to_sample();
        check("e_grant_x0", 32'(pipe_grant), 32'd0);
        to_next();
        drive(1'b0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd0, 32'h0BAD);
        to_sample();
        check("e_ready_x0", 32'(mdu_ready), 32'd1);
        to_next();
        drive(1'b1, 1'b0, 5'd5, 32'h5555, 1'b0, 5'd0, 32'd0);
        to_sample();
        check("e_grant_nowrite", 32'(pipe_grant), 32'd0);
        check("e_mask_x0", pending_mask, 32'd0);
        to_next();

        // Reset while full and stalled
        for (int k = 0; k <= 4; k++) begin
            if (k == 0)      drive(1'b1, 1'b1, 5'd3, 32'h400, 1'b1, 5'd13, 32'hD0D0);
            else if (k == 1) drive(1'b1, 1'b1, 5'd3, 32'h401, 1'b1, 5'd14, 32'hE0E0);
            else             drive(1'b1, 1'b1, 5'd3, 32'h400 + 32'(k), 1'b0, 5'd0, 32'd0);
            expect_wb(5'd3, 32'h400 + 32'(k));
            to_next();
        end
        idle();
        reset = 1'b1;
        to_sample();
        check("f_stall_before", 32'(stall_req), 32'd1);
        check("f_mask_before", pending_mask, 32'h0000_6000);
        check("f_rst_ready", 32'(mdu_ready), 32'd0);
        to_next();
        reset = 1'b0;
        to_sample();
        check("f_stall_after", 32'(stall_req), 32'd0);
        check("f_mask_after", pending_mask, 32'd0);
        check("f_ready_after", 32'(mdu_ready), 32'd1);
        to_next();
        to_sample();
        check("f_still_empty", pending_mask, 32'd0);
        to_next();
        to_next();

        check("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
